// File: rtl/store_monitor_if.sv
// store_monitor_if: data-memory write port plus verdict/status signals of store_monitor.
// Log FIFO signals exist only when STORE_LOG_EN is defined.
interface store_monitor_if #(parameter int CNT_W = 16);
  logic MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic done;
  logic pass;
  logic fail;
  logic timeout;
  logic [CNT_W-1:0] store_count;
  logic [31:0] last_adr;
  logic [31:0] last_data;
`ifdef STORE_LOG_EN
  logic log_rd;
  logic log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic log_ovf;
  modport master(output MemWrite, DataAdr, WriteData, log_rd,
                 input done, pass, fail, timeout, store_count, last_adr, last_data,
                 log_valid, log_adr, log_data, log_ovf);
  modport slave(input MemWrite, DataAdr, WriteData, log_rd,
                output done, pass, fail, timeout, store_count, last_adr, last_data,
                log_valid, log_adr, log_data, log_ovf);
`else
  modport master(output MemWrite, DataAdr, WriteData,
                 input done, pass, fail, timeout, store_count, last_adr, last_data);
  modport slave(input MemWrite, DataAdr, WriteData,
                output done, pass, fail, timeout, store_count, last_adr, last_data);
`endif
endinterface

// File: rtl/store_monitor.sv
// store_monitor: judges a program's stores as pass/fail/timeout with sticky registered flags.
// Define STORE_LOG_EN to add an 8-entry FIFO logging every accepted store.
module store_monitor #(
  parameter logic [31:0] PASS_ADR = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [31:0] ALLOWED_ADR = 32'd96,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  store_monitor_if.slave bus
);
  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] cycleCnt;
  logic isRun, isPass, isFail, isAccept, isTimeout;
  assign isRun = state == RUN;
  assign isPass = isRun && bus.MemWrite && bus.DataAdr == PASS_ADR && bus.WriteData == PASS_DATA;
  assign isFail = isRun && bus.MemWrite && !isPass && bus.DataAdr != ALLOWED_ADR;
  assign isAccept = isRun && bus.MemWrite && !isPass && bus.DataAdr == ALLOWED_ADR;
  // >= rather than == so a store on the last cycle defers the timeout by one edge
  assign isTimeout = isRun && !bus.MemWrite && cycleCnt >= TIMEOUT_LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cycleCnt <= '0;
      bus.pass <= 1'b0;
      bus.fail <= 1'b0;
      bus.timeout <= 1'b0;
      bus.done <= 1'b0;
      bus.store_count <= '0;
      bus.last_adr <= '0;
      bus.last_data <= '0;
    end else begin
      if (isRun && cycleCnt != '1) cycleCnt <= cycleCnt + 1'b1;
      if (isAccept && bus.store_count != '1) bus.store_count <= bus.store_count + 1'b1;
      if (isPass || isFail) begin
        bus.last_adr <= bus.DataAdr;
        bus.last_data <= bus.WriteData;
      end
      if (isPass || isFail || isTimeout) begin
        state <= isPass ? PASS : isFail ? FAIL : TIMEOUT;
        bus.done <= 1'b1;
      end
      if (isPass) bus.pass <= 1'b1;
      if (isFail) bus.fail <= 1'b1;
      if (isTimeout) bus.timeout <= 1'b1;
    end
  end
`ifdef STORE_LOG_EN
  logic [31:0] logAdrMem [8];
  logic [31:0] logDataMem [8];
  logic [2:0] wrPtr, rdPtr;
  logic [3:0] logCnt;
  logic logPop, logFull, logPush;
  assign logPop = bus.log_rd && logCnt != 4'd0;
  assign logFull = logCnt == 4'd8;
  assign logPush = isAccept && (!logFull || logPop);
  assign bus.log_valid = logCnt != 4'd0;
  assign bus.log_adr = logAdrMem[rdPtr];
  assign bus.log_data = logDataMem[rdPtr];
  always_ff @(posedge clk) begin
    if (logPush) begin
      logAdrMem[wrPtr] <= bus.DataAdr;
      logDataMem[wrPtr] <= bus.WriteData;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      logCnt <= '0;
      bus.log_ovf <= 1'b0;
    end else begin
      if (logPush) wrPtr <= wrPtr + 1'b1;
      if (logPop) rdPtr <= rdPtr + 1'b1;
      logCnt <= logCnt + 4'(logPush) - 4'(logPop);
      if (isAccept && !logPush) bus.log_ovf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: scoreboard bench for store_monitor; expected outputs come from a reference model.
module tb_store_monitor;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  store_monitor_if #(.CNT_W(16)) bus();
  store_monitor #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] pass, fail, timeout, done, sc, la, ld, lv, lh, lo;
  } exp_t;
  exp_t sb[$];
  int mSt, mCnt, mCyc;
  logic [31:0] mLa, mLd;
  logic [31:0] mQ[$];
  logic mOvf;
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic mw, input logic [31:0] a, input logic [31:0] d, input logic lr);
    exp_t e;
    bit acc, full, popOk;
    reset = r;
    bus.MemWrite = mw;
    bus.DataAdr = a;
    bus.WriteData = d;
`ifdef STORE_LOG_EN
    bus.log_rd = lr;
`endif
    acc = 0;
    if (r) begin
      mSt = 0; mCnt = 0; mCyc = 0; mLa = 0; mLd = 0; mOvf = 0;
      mQ.delete();
    end else begin
      if (mSt == 0) begin
        if (mw && a == 100 && d == 7) begin mSt = 1; mLa = a; mLd = d; end
        else if (mw && a != 96) begin mSt = 2; mLa = a; mLd = d; end
        else if (mw) begin acc = 1; if (mCnt < 65535) mCnt++; mCyc++; end
        else if (mCyc >= TO - 1) mSt = 3;
        else mCyc++;
      end
      full = mQ.size() == 8;
      popOk = lr && mQ.size() > 0;
      if (acc && full && !popOk) mOvf = 1;
      if (popOk) void'(mQ.pop_front());
      if (acc && (!full || popOk)) mQ.push_back(d);
    end
    e.pass = 32'(mSt == 1);
    e.fail = 32'(mSt == 2);
    e.timeout = 32'(mSt == 3);
    e.done = 32'(mSt != 0);
    e.sc = mCnt;
    e.la = mLa;
    e.ld = mLd;
    e.lv = 32'(mQ.size() > 0);
    e.lh = mQ.size() > 0 ? mQ[0] : 32'd0;
    e.lo = 32'(mOvf);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkVal("pass", 32'(bus.pass), e.pass);
    checkVal("fail", 32'(bus.fail), e.fail);
    checkVal("timeout", 32'(bus.timeout), e.timeout);
    checkVal("done", 32'(bus.done), e.done);
    checkVal("store_count", 32'(bus.store_count), e.sc);
    checkVal("last_adr", bus.last_adr, e.la);
    checkVal("last_data", bus.last_data, e.ld);
`ifdef STORE_LOG_EN
    checkVal("log_valid", 32'(bus.log_valid), e.lv);
    if (e.lv[0]) checkVal("log_data", bus.log_data, e.lh);
    if (e.lv[0]) checkVal("log_adr", bus.log_adr, 32'd96);
    checkVal("log_ovf", 32'(bus.log_ovf), e.lo);
`endif
  endtask
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask
  initial begin
    bus.MemWrite = 0;
    bus.DataAdr = 0;
    bus.WriteData = 0;
`ifdef STORE_LOG_EN
    bus.log_rd = 0;
`endif
    doReset(3);
    checkVal("reset_done", 32'(bus.done), 0);
    step(0, 1, 96, 3, 0);
    step(0, 1, 96, 4, 0);
    step(0, 1, 100, 7, 0);
    checkVal("plan_pass", 32'(bus.pass), 1);
    checkVal("plan_count", 32'(bus.store_count), 2);
    checkVal("plan_last_adr", bus.last_adr, 100);
    step(0, 1, 64, 1, 0);
    checkVal("pass_absorbing", 32'(bus.fail), 0);
    doReset(1);
    step(0, 1, 100, 6, 0);
    checkVal("wrong_data_fail", 32'(bus.fail), 1);
    checkVal("wrong_data_last", bus.last_data, 6);
    step(0, 1, 100, 7, 0);
    step(0, 1, 96, 2, 0);
    checkVal("fail_absorbing", 32'(bus.pass), 0);
    doReset(1);
    step(0, 0, 100, 7, 0);
    step(0, 0, 64, 9, 0);
    checkVal("idle_no_effect", bus.last_adr, 0);
    step(0, 1, 64, 7, 0);
    checkVal("illegal_fail", 32'(bus.fail), 1);
    checkVal("illegal_adr", bus.last_adr, 64);
    doReset(1);
    for (int i = 0; i < TO + 5; i++) begin
      step(0, 0, 0, 0, 0);
      checkVal("timeout_exact", 32'(bus.timeout), 32'(i >= TO - 1));
    end
    doReset(1);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 96, 5, 0);
    checkVal("store_wins_timeout", 32'(bus.timeout), 0);
    step(0, 0, 0, 0, 0);
    checkVal("deferred_timeout", 32'(bus.timeout), 1);
    doReset(1);
    step(0, 1, 100, 7, 0);
    step(1, 0, 0, 0, 0);
    checkVal("midreset_clear", 32'(bus.pass), 0);
    step(0, 1, 96, 1, 0);
    step(0, 1, 100, 7, 0);
    checkVal("repass", 32'(bus.pass), 1);
    checkVal("repass_count", 32'(bus.store_count), 1);
`ifdef STORE_LOG_EN
    doReset(1);
    for (int i = 1; i <= 9; i++) step(0, 1, 96, 32'(i), 0);
    checkVal("log_ovf_set", 32'(bus.log_ovf), 1);
    checkVal("log_head_1", bus.log_data, 1);
    for (int i = 1; i <= 8; i++) begin
      checkVal("log_pop_order", bus.log_data, 32'(i));
      step(0, 0, 0, 0, 1);
    end
    checkVal("log_empty", 32'(bus.log_valid), 0);
    step(0, 0, 0, 0, 1);
    doReset(1);
    for (int i = 1; i <= 8; i++) step(0, 1, 96, 32'(i + 16), 0);
    step(0, 1, 96, 99, 1);
    checkVal("full_pushpop_no_ovf", 32'(bus.log_ovf), 0);
`endif
    for (int r = 0; r < 6; r++) begin
      doReset(1);
      for (int i = 0; i < 12; i++) begin
        int s;
        logic [31:0] a;
        s = int'($urandom_range(0, 4));
        a = s < 3 ? 32'd96 : s == 3 ? 32'd100 : 32'd64;
        step(0, 1'($urandom_range(0, 1)), a, 32'($urandom_range(6, 8)), 1'($urandom_range(0, 1)));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
